// File: rtl/pc_unit.sv
// Program counter with clock divider, branch/jump/call/return and a circular return-address stack.
// Latency: pc updates on the rising edge where step=1 (every DIV clocks); pc_plus is combinational.
// No backpressure: stall holds pc and stack for one step; controls are ignored off-step.
module pc_unit #(
   parameter int unsigned           WIDTH     = 32,
   parameter logic [WIDTH-1:0]      RESET_VEC = '0,
   parameter logic [WIDTH-1:0]      INC       = 4,
   parameter int unsigned           DIV       = 2,
   parameter int unsigned           RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stall,
   input  logic             br_taken,
   input  logic [WIDTH-1:0] br_off,
   input  logic             jmp,
   input  logic             call,
   input  logic             ret,
   input  logic [WIDTH-1:0] jmp_addr,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus,
   output logic             step,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_ovf,
   output logic             ras_unf
);

   localparam int unsigned DCNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned IDX_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(RAS_DEPTH + 1);

   localparam logic [DCNT_W-1:0] DIV_LAST = DCNT_W'(DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(RAS_DEPTH - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(RAS_DEPTH);

   logic [DCNT_W-1:0] div_cnt_q, div_cnt_d;
   logic [WIDTH-1:0]  pc_q, pc_d;
   logic [WIDTH-1:0]  ras_q [RAS_DEPTH];
   logic [WIDTH-1:0]  ras_d [RAS_DEPTH];
   logic [IDX_W-1:0]  ras_top_q, ras_top_d;   // index of the most recent entry
   logic [CNT_W-1:0]  ras_cnt_q, ras_cnt_d;   // number of valid entries
   logic              ras_ovf_q, ras_ovf_d;
   logic              ras_unf_q, ras_unf_d;

   logic [IDX_W-1:0]  top_next;
   logic [IDX_W-1:0]  top_prev;

   assign step      = (div_cnt_q == DIV_LAST);
   assign pc        = pc_q;
   assign pc_plus   = pc_q + INC;
   assign ras_empty = (ras_cnt_q == '0);
   assign ras_full  = (ras_cnt_q == CNT_MAX);
   assign ras_ovf   = ras_ovf_q;
   assign ras_unf   = ras_unf_q;

   // Circular neighbours of the top index; when full, top_next is the oldest entry.
   always_comb begin
      top_next = (ras_top_q == IDX_LAST) ? '0 : ras_top_q + 1'b1;
      top_prev = (ras_top_q == '0) ? IDX_LAST : ras_top_q - 1'b1;
   end

   // Divider free-runs 0..DIV-1 regardless of stall.
   always_comb begin
      div_cnt_d = step ? '0 : div_cnt_q + 1'b1;
   end

   // Next-PC and stack update, evaluated only on step cycles, priority start>stall>ret>call>jmp>br>seq.
   always_comb begin
      pc_d      = pc_q;
      ras_d     = ras_q;
      ras_top_d = ras_top_q;
      ras_cnt_d = ras_cnt_q;
      ras_ovf_d = ras_ovf_q;
      ras_unf_d = ras_unf_q;
      if (step) begin
         if (start) begin
            pc_d      = RESET_VEC;
            ras_top_d = '0;
            ras_cnt_d = '0;
            ras_ovf_d = 1'b0;
            ras_unf_d = 1'b0;
         end else if (stall) begin
            pc_d = pc_q;
         end else if (ret) begin
            if (ras_cnt_q != '0) begin
               pc_d      = ras_q[ras_top_q];
               ras_top_d = top_prev;
               ras_cnt_d = ras_cnt_q - 1'b1;
            end else begin
               pc_d      = pc_plus;
               ras_unf_d = 1'b1;
            end
         end else if (call) begin
            pc_d            = jmp_addr;
            ras_d[top_next] = pc_plus;
            ras_top_d       = top_next;
            if (ras_cnt_q == CNT_MAX) begin
               ras_ovf_d = 1'b1;
            end else begin
               ras_cnt_d = ras_cnt_q + 1'b1;
            end
         end else if (jmp) begin
            pc_d = jmp_addr;
         end else if (br_taken) begin
            pc_d = pc_q + br_off;
         end else begin
            pc_d = pc_plus;
         end
      end
   end

   // State registers; reset abandons any pending update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
         pc_q      <= RESET_VEC;
         ras_top_q <= '0;
         ras_cnt_q <= '0;
         ras_ovf_q <= 1'b0;
         ras_unf_q <= 1'b0;
         for (int i = 0; i < int'(RAS_DEPTH); i++) begin
            ras_q[i] <= '0;
         end
      end else begin
         div_cnt_q <= div_cnt_d;
         pc_q      <= pc_d;
         ras_top_q <= ras_top_d;
         ras_cnt_q <= ras_cnt_d;
         ras_ovf_q <= ras_ovf_d;
         ras_unf_q <= ras_unf_d;
         ras_q     <= ras_d;
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with DIV=2, INC=4, RESET_VEC=0, WIDTH=32, RAS_DEPTH=4.
// Inputs are driven and outputs sampled on the falling edge, away from the active edge.
// Each scenario task carries its own hand-computed expectations.
module tb_pc_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_off;
   logic        jmp;
   logic        call;
   logic        ret;
   logic [31:0] jmp_addr;
   logic [31:0] pc;
   logic [31:0] pc_plus;
   logic        step;
   logic        ras_empty;
   logic        ras_full;
   logic        ras_ovf;
   logic        ras_unf;

   int total;
   int bad;

   pc_unit #(
      .WIDTH     (32),
      .RESET_VEC (32'h0),
      .INC       (32'h4),
      .DIV       (2),
      .RAS_DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stall     (stall),
      .br_taken  (br_taken),
      .br_off    (br_off),
      .jmp       (jmp),
      .call      (call),
      .ret       (ret),
      .jmp_addr  (jmp_addr),
      .pc        (pc),
      .pc_plus   (pc_plus),
      .step      (step),
      .ras_empty (ras_empty),
      .ras_full  (ras_full),
      .ras_ovf   (ras_ovf),
      .ras_unf   (ras_unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      start    = 1'b0;
      stall    = 1'b0;
      br_taken = 1'b0;
      br_off   = 32'h0;
      jmp      = 1'b0;
      call     = 1'b0;
      ret      = 1'b0;
      jmp_addr = 32'h0;
   endtask

   // Wait (bounded) for a step cycle, present the controls across its rising edge, then release them.
   task automatic apply_step(input logic s_start, input logic s_stall, input logic s_br,
                             input logic [31:0] s_off, input logic s_jmp, input logic s_call,
                             input logic s_ret, input logic [31:0] s_addr);
      int n;
      n = 0;
      while (step !== 1'b1 && n < 4) begin
         @(negedge clk);
         #1;
         n++;
      end
      total++;
      if (step !== 1'b1) begin
         bad++;
         $display("FAIL step_timeout step=%b required=1", step);
      end
      start    = s_start;
      stall    = s_stall;
      br_taken = s_br;
      br_off   = s_off;
      jmp      = s_jmp;
      call     = s_call;
      ret      = s_ret;
      jmp_addr = s_addr;
      @(negedge clk);
      clear_inputs();
      #1;
   endtask

   task automatic test_reset();
      #12;
      total++; if (pc !== 32'h0)      begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
      total++; if (pc_plus !== 32'h4) begin bad++; $display("FAIL reset_pc_plus got=%h exp=%h", pc_plus, 32'h4); end
      total++; if (step !== 1'b0)     begin bad++; $display("FAIL reset_step got=%b exp=0", step); end
      total++; if (ras_empty !== 1'b1 || ras_full !== 1'b0)
         begin bad++; $display("FAIL reset_ras_status empty=%b full=%b exp 1/0", ras_empty, ras_full); end
      total++; if (ras_ovf !== 1'b0 || ras_unf !== 1'b0)
         begin bad++; $display("FAIL reset_flags ovf=%b unf=%b exp 0/0", ras_ovf, ras_unf); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_sequential();
      logic        exp_step [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] exp_pc   [6] = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h8, 32'h8};
      for (int i = 0; i < 6; i++) begin
         #1;
         total++; if (step !== exp_step[i])
            begin bad++; $display("FAIL seq_step[%0d] got=%b exp=%b", i, step, exp_step[i]); end
         total++; if (pc !== exp_pc[i])
            begin bad++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc, exp_pc[i]); end
         @(negedge clk);
      end
   endtask

   task automatic test_branch();
      apply_step(0, 0, 0, 32'h0, 1, 0, 0, 32'h10);
      total++; if (pc !== 32'h10) begin bad++; $display("FAIL br_setup got=%h exp=%h", pc, 32'h10); end
      apply_step(0, 0, 1, 32'hFFFF_FFF8, 0, 0, 0, 32'h0);
      total++; if (pc !== 32'h08) begin bad++; $display("FAIL br_back got=%h exp=%h", pc, 32'h08); end
      // same branch presented on a non-step cycle must be ignored
      total++; if (step !== 1'b0) begin bad++; $display("FAIL br_offstep_phase step=%b exp=0", step); end
      br_taken = 1'b1;
      br_off   = 32'hFFFF_FFF8;
      @(negedge clk);
      clear_inputs();
      #1;
      total++; if (pc !== 32'h08) begin bad++; $display("FAIL br_offstep_hold got=%h exp=%h", pc, 32'h08); end
      apply_step(0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
      total++; if (pc !== 32'h0C) begin bad++; $display("FAIL br_offstep_seq got=%h exp=%h", pc, 32'h0C); end
   endtask

   task automatic test_call_ret();
      apply_step(0, 0, 0, 32'h0, 1, 0, 0, 32'h20);
      apply_step(0, 0, 0, 32'h0, 0, 1, 0, 32'h100);
      total++; if (pc !== 32'h100)   begin bad++; $display("FAIL call_pc got=%h exp=%h", pc, 32'h100); end
      total++; if (ras_empty !== 1'b0) begin bad++; $display("FAIL call_empty got=%b exp=0", ras_empty); end
      apply_step(0, 0, 0, 32'h0, 0, 0, 1, 32'h0);
      total++; if (pc !== 32'h24)    begin bad++; $display("FAIL ret_pc got=%h exp=%h", pc, 32'h24); end
      total++; if (ras_empty !== 1'b1) begin bad++; $display("FAIL ret_empty got=%b exp=1", ras_empty); end
   endtask

   task automatic test_overflow();
      logic [31:0] exp_ret [4] = '{32'h44, 32'h34, 32'h24, 32'h14};
      for (int i = 0; i < 5; i++) begin
         apply_step(0, 0, 0, 32'h0, 1, 0, 0, 32'(i * 16));
         apply_step(0, 0, 0, 32'h0, 0, 1, 0, 32'h200);
         total++; if (pc !== 32'h200) begin bad++; $display("FAIL ovf_call_pc[%0d] got=%h exp=%h", i, pc, 32'h200); end
         if (i == 3) begin
            total++; if (ras_full !== 1'b1 || ras_ovf !== 1'b0)
               begin bad++; $display("FAIL ovf_fill full=%b ovf=%b exp 1/0", ras_full, ras_ovf); end
         end
      end
      total++; if (ras_full !== 1'b1 || ras_ovf !== 1'b1)
         begin bad++; $display("FAIL ovf_set full=%b ovf=%b exp 1/1", ras_full, ras_ovf); end
      for (int i = 0; i < 4; i++) begin
         apply_step(0, 0, 0, 32'h0, 0, 0, 1, 32'h0);
         total++; if (pc !== exp_ret[i]) begin bad++; $display("FAIL ovf_ret_pc[%0d] got=%h exp=%h", i, pc, exp_ret[i]); end
      end
      total++; if (ras_empty !== 1'b1 || ras_ovf !== 1'b1)
         begin bad++; $display("FAIL ovf_drained empty=%b ovf=%b exp 1/1", ras_empty, ras_ovf); end
      apply_step(1, 0, 0, 32'h0, 0, 0, 0, 32'h0);
      total++; if (pc !== 32'h0 || ras_ovf !== 1'b0)
         begin bad++; $display("FAIL ovf_start_clear pc=%h ovf=%b exp 0/0", pc, ras_ovf); end
   endtask

   task automatic test_underflow();
      apply_step(0, 0, 0, 32'h0, 1, 0, 0, 32'h8);
      apply_step(0, 0, 0, 32'h0, 0, 0, 1, 32'h0);
      total++; if (pc !== 32'h0C || ras_unf !== 1'b1)
         begin bad++; $display("FAIL unf_ret pc=%h unf=%b exp 0000000c/1", pc, ras_unf); end
      apply_step(0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
      total++; if (pc !== 32'h10 || ras_unf !== 1'b1)
         begin bad++; $display("FAIL unf_sticky pc=%h unf=%b exp 00000010/1", pc, ras_unf); end
      // call together with ret: ret wins, nothing pushed
      apply_step(0, 0, 0, 32'h0, 0, 1, 1, 32'h300);
      total++; if (pc !== 32'h14 || ras_empty !== 1'b1)
         begin bad++; $display("FAIL callret_pri pc=%h empty=%b exp 00000014/1", pc, ras_empty); end
      apply_step(1, 0, 0, 32'h0, 0, 0, 0, 32'h0);
      total++; if (pc !== 32'h0 || ras_unf !== 1'b0)
         begin bad++; $display("FAIL unf_start_clear pc=%h unf=%b exp 0/0", pc, ras_unf); end
   endtask

   task automatic test_priority();
      apply_step(0, 0, 0, 32'h0, 1, 0, 0, 32'h40);
      apply_step(0, 0, 0, 32'h0, 0, 1, 0, 32'h80);
      // stall beats ret and jmp
      apply_step(0, 1, 0, 32'h0, 1, 0, 1, 32'h500);
      total++; if (pc !== 32'h80 || ras_empty !== 1'b0)
         begin bad++; $display("FAIL stall_hold pc=%h empty=%b exp 00000080/0", pc, ras_empty); end
      // jmp beats br_taken
      apply_step(0, 0, 1, 32'h100, 1, 0, 0, 32'h600);
      total++; if (pc !== 32'h600) begin bad++; $display("FAIL jmp_over_br got=%h exp=%h", pc, 32'h600); end
      // call beats jmp and pushes 0x604
      apply_step(0, 0, 0, 32'h0, 1, 1, 0, 32'h700);
      total++; if (pc !== 32'h700) begin bad++; $display("FAIL call_over_jmp got=%h exp=%h", pc, 32'h700); end
      apply_step(0, 0, 0, 32'h0, 0, 0, 1, 32'h0);
      total++; if (pc !== 32'h604) begin bad++; $display("FAIL pri_ret1 got=%h exp=%h", pc, 32'h604); end
      apply_step(0, 0, 0, 32'h0, 0, 0, 1, 32'h0);
      total++; if (pc !== 32'h44)  begin bad++; $display("FAIL pri_ret2 got=%h exp=%h", pc, 32'h44); end
      // start beats stall
      apply_step(1, 1, 0, 32'h0, 0, 0, 0, 32'h0);
      total++; if (pc !== 32'h0) begin bad++; $display("FAIL start_over_stall got=%h exp=%h", pc, 32'h0); end
   endtask

   task automatic test_wrap_and_reset();
      apply_step(0, 0, 0, 32'h0, 1, 0, 0, 32'hFFFF_FFFC);
      total++; if (pc_plus !== 32'h0) begin bad++; $display("FAIL wrap_pc_plus got=%h exp=%h", pc_plus, 32'h0); end
      apply_step(0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
      total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_seq got=%h exp=%h", pc, 32'h0); end
      apply_step(0, 0, 0, 32'h0, 1, 0, 0, 32'h30);
      apply_step(0, 0, 0, 32'h0, 0, 0, 1, 32'h0);
      apply_step(0, 0, 0, 32'h0, 0, 1, 0, 32'h60);
      total++; if (pc !== 32'h60 || ras_empty !== 1'b0 || ras_unf !== 1'b1)
         begin bad++; $display("FAIL prerst pc=%h empty=%b unf=%b exp 00000060/0/1", pc, ras_empty, ras_unf); end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++; if (pc !== 32'h0 || step !== 1'b0)
         begin bad++; $display("FAIL midrst_pc pc=%h step=%b exp 0/0", pc, step); end
      total++; if (ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_unf !== 1'b0 || ras_ovf !== 1'b0)
         begin bad++; $display("FAIL midrst_ras empty=%b full=%b unf=%b ovf=%b exp 1/0/0/0", ras_empty, ras_full, ras_unf, ras_ovf); end
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      total++; if (step !== 1'b1 || pc !== 32'h0)
         begin bad++; $display("FAIL postrst_first step=%b pc=%h exp 1/0", step, pc); end
      @(negedge clk);
      #1;
      total++; if (pc !== 32'h4) begin bad++; $display("FAIL postrst_seq got=%h exp=%h", pc, 32'h4); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      clear_inputs();
      test_reset();
      test_sequential();
      test_branch();
      test_call_ret();
      test_overflow();
      test_underflow();
      test_priority();
      test_wrap_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, PC/address width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 0, PC value after reset or restart.
REQ-003 SHALL have parameter INC, default 4, sequential PC increment.
REQ-004 SHALL have parameter DIV, default 2, range >=1, clk cycles per PC step.
REQ-005 SHALL have parameter RAS_DEPTH, default 4, range >=1, return-address stack entries.
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have port start, input, 1, synchronous restart to RESET_VEC.
REQ-009 SHALL have port stall, input, 1, hold PC this step.
REQ-010 SHALL have port br_taken, input, 1, PC-relative branch.
REQ-011 SHALL have port br_off, input, WIDTH, two's-complement branch offset.
REQ-012 SHALL have port jmp, input, 1, absolute jump.
REQ-013 SHALL have port call, input, 1, absolute jump that also pushes the return address.
REQ-014 SHALL have port ret, input, 1, pop the return address into PC.
REQ-015 SHALL have port jmp_addr, input, WIDTH, target for jmp/call.
REQ-016 SHALL have port pc, output, WIDTH, current PC, registered.
REQ-017 SHALL have port pc_plus, output, WIDTH, pc+INC, combinational.
REQ-018 SHALL have port step, output, 1, high on the cycle the PC updates.
REQ-019 SHALL have port ras_empty / ras_full, output, 1 each, stack status.
REQ-020 SHALL have port ras_ovf / ras_unf, output, 1 each, sticky overflow/underflow flags.

Function
REQ-021 A divider counter div_cnt SHALL count 0..DIV-1 and wrap; step SHALL be (div_cnt==DIV-1); DIV=1 gives step=1 every cycle.
REQ-022 PC, stack and flags SHALL update only on clock edges where step=1; control inputs SHALL be sampled only then and ignored otherwise.
REQ-023 Next-PC priority on a step SHALL be start > stall > ret > call > jmp > br_taken > sequential (pc+INC).
REQ-024 start SHALL load pc=RESET_VEC, empty the stack, and clear ras_ovf/ras_unf.
REQ-025 stall SHALL hold pc and the stack unchanged; the divider SHALL keep running.
REQ-026 ret with the stack non-empty SHALL load pc=top entry and pop it.
REQ-027 ret with the stack empty SHALL load pc=pc+INC and set ras_unf.
REQ-028 call SHALL load pc=jmp_addr and push pc+INC.
REQ-029 A push when full SHALL overwrite the oldest entry (circular), keep ras_full=1, and set ras_ovf.
REQ-030 call and ret asserted together SHALL behave as ret only; the call SHALL be ignored.
REQ-031 jmp SHALL load pc=jmp_addr; br_taken SHALL load pc=pc+br_off.
REQ-032 All PC arithmetic SHALL be modulo 2^WIDTH; carry-out SHALL be discarded, with no other effect on wrap-around.
REQ-033 ras_ovf and ras_unf SHALL stay set until rst_n or start clears them.

Reset
REQ-034 rst_n low SHALL immediately force pc=RESET_VEC, div_cnt=0, the stack empty (ras_empty=1, ras_full=0), and ras_ovf=ras_unf=0, regardless of clk.
REQ-035 After release, the first step SHALL occur on the DIV-th rising edge; reset asserted mid-operation SHALL abandon any pending update.

Verification (DIV=2, INC=4, RESET_VEC=0, WIDTH=32, RAS_DEPTH=4)
REQ-036 Release reset, no controls for 6 cycles -> step=0,1,0,1,0,1; pc=0,0,4,4,8,8.
REQ-037 At pc=0x10, br_taken=1, br_off=0xFFFFFFF8 on a step -> pc=0x08; the same input on a non-step cycle -> ignored.
REQ-038 At pc=0x20, call with jmp_addr=0x100 -> pc=0x100, ras_empty=0; then ret -> pc=0x24, ras_empty=1.
REQ-039 Five calls from pc=0x0,0x10,0x20,0x30,0x40 -> ras_ovf=1, ras_full=1; four rets -> pc=0x44,0x34,0x24,0x14, then ras_empty=1.
REQ-040 ret on an empty stack at pc=0x8 -> pc=0xC, ras_unf=1, which stays set; start -> pc=0 on the next step and ras_unf=0.
REQ-041 pc=0xFFFFFFFC sequential -> pc=0x0; rst_n pulsed low mid-divide -> pc=0 and div_cnt=0 immediately, and the stack is emptied.
